// File: rtl/instr_register_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : instr_register_pkg                                           |
// | Description : Shared types for the instruction register and its execution  |
// |               unit, plus the opcode evaluation function.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package instr_register_pkg;

    localparam int DEPTH = 32;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef logic [IDX_W-1:0]   index_t;
    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    // Evaluates one instruction on 64-bit sign-extended operands. A zero divisor
    // on DIV/MOD returns 0 and raises div0; the caller picks the final value.
    function automatic result_t exec_op(input instruction_t instr, output logic div0);
        result_t a;
        result_t b;
        result_t r;
        a    = {{32{instr.op_a[31]}}, instr.op_a};
        b    = {{32{instr.op_b[31]}}, instr.op_b};
        r    = '0;
        div0 = 1'b0;
        case (instr.opc)
            ZERO:  r = '0;
            PASSA: r = a;
            PASSB: r = b;
            ADD:   r = a + b;
            SUB:   r = a - b;
            MULT:  r = a * b;
            DIV: begin
                if (b == '0) div0 = 1'b1;
                else         r    = a / b;
            end
            MOD: begin
                if (b == '0) div0 = 1'b1;
                else         r    = a % b;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_exec_unit_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_alu                                                    |
// | Description : Combinational execute stage sitting between stage1 and the   |
// |               output register of instr_exec_unit.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_alu
    import instr_register_pkg::*;
#(
    parameter result_t DIV0_RESULT = '0
) (
    input  instruction_t instr,
    output result_t      result,
    output logic         div_by_zero
);

    logic    w_div0;
    result_t w_raw;

    // Evaluate the opcode and substitute the configured value on a zero divisor
    always_comb begin
        w_div0      = 1'b0;
        w_raw       = exec_op(instr, w_div0);
        div_by_zero = w_div0;
        result      = w_div0 ? DIV0_RESULT : w_raw;
    end

endmodule
`default_nettype wire

// File: rtl/instr_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_exec_unit                                              |
// | Description : Walks a window of instruction register entries, executes     |
// |               each in a 2-stage pipeline and streams results out on a      |
// |               valid/ready interface with backpressure.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter result_t DIV0_RESULT = '0
) (
    input  logic               clk,
    input  logic               reset_en,
    input  logic               start,
    input  index_t             start_index,
    input  logic [CNT_W-1:0]   count,
    output index_t             read_index,
    input  instruction_t       instruction,
    output logic               res_valid,
    input  logic               res_ready,
    output result_t            result,
    output opcode_t            res_opcode,
    output index_t             res_index,
    output logic               div_by_zero,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [CNT_W-1:0]   remaining_q,   remaining_d;
    index_t             read_index_q,  read_index_d;
    logic               done_q,        done_d;

    logic               s1_valid_q,    s1_valid_d;
    instruction_t       s1_instr_q,    s1_instr_d;
    index_t             s1_index_q,    s1_index_d;

    logic               res_valid_q,   res_valid_d;
    result_t            result_q,      result_d;
    opcode_t            res_opcode_q,  res_opcode_d;
    index_t             res_index_q,   res_index_d;
    logic               div_by_zero_q, div_by_zero_d;

    logic               w_out_load;
    logic               w_s1_load;
    logic               w_fetch;
    index_t             w_next_index;
    result_t            w_alu_result;
    logic               w_alu_div0;

    instr_alu #(
        .DIV0_RESULT (DIV0_RESULT)
    ) u_alu (
        .instr       (s1_instr_q),
        .result      (w_alu_result),
        .div_by_zero (w_alu_div0)
    );

    // Pipeline advance conditions; the output stage frees up when empty or accepted
    always_comb begin
        w_out_load   = !res_valid_q || res_ready;
        w_s1_load    = !s1_valid_q || w_out_load;
        w_fetch      = (state_q == ST_RUN) && (remaining_q != '0) && w_s1_load;
        w_next_index = (read_index_q == index_t'(DEPTH - 1)) ? '0
                                                              : read_index_q + index_t'(1);
    end

    // Sequencer next state: window accept, fetch bookkeeping and drain-complete pulse
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        read_index_d = read_index_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d      = ST_RUN;
                        remaining_d  = count;
                        read_index_d = start_index;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_fetch) begin
                    remaining_d  = remaining_q - 1'b1;
                    read_index_d = w_next_index;
                    if (remaining_q == CNT_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Empty once stage1 is idle and the output beat (if any) leaves now
                if (!s1_valid_q && w_out_load) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage1 capture and output stage load, each holding when blocked downstream
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_instr_d    = s1_instr_q;
        s1_index_d    = s1_index_q;
        res_valid_d   = res_valid_q;
        result_d      = result_q;
        res_opcode_d  = res_opcode_q;
        res_index_d   = res_index_q;
        div_by_zero_d = div_by_zero_q;

        if (w_out_load) begin
            res_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d      = w_alu_result;
                res_opcode_d  = s1_instr_q.opc;
                res_index_d   = s1_index_q;
                div_by_zero_d = w_alu_div0;
            end
        end

        if (w_s1_load) begin
            s1_valid_d = w_fetch;
            if (w_fetch) begin
                s1_instr_d = instruction;
                s1_index_d = read_index_q;
            end
        end
    end

    // State register; an asserted reset aborts any window without a done pulse
    always_ff @(posedge clk or negedge reset_en) begin
        if (!reset_en) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            read_index_q  <= '0;
            done_q        <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_instr_q    <= '0;
            s1_index_q    <= '0;
            res_valid_q   <= 1'b0;
            result_q      <= '0;
            res_opcode_q  <= ZERO;
            res_index_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            read_index_q  <= read_index_d;
            done_q        <= done_d;
            s1_valid_q    <= s1_valid_d;
            s1_instr_q    <= s1_instr_d;
            s1_index_q    <= s1_index_d;
            res_valid_q   <= res_valid_d;
            result_q      <= result_d;
            res_opcode_q  <= res_opcode_d;
            res_index_q   <= res_index_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign read_index  = read_index_q;
    assign res_valid   = res_valid_q;
    assign result      = result_q;
    assign res_opcode  = res_opcode_q;
    assign res_index   = res_index_q;
    assign div_by_zero = div_by_zero_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_exec_unit                                           |
// | Description : Self-checking bench for instr_exec_unit with an instruction  |
// |               memory model, scoreboard and reference execution model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    typedef struct {
        opcode_t opc;
        int      a;
        int      b;
        longint  r;
        bit      d0;
        int      idx;
    } vec_t;

    typedef struct {
        longint  r;
        opcode_t op;
        int      idx;
        bit      d0;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset_en;
    logic             start;
    index_t           start_index;
    logic [CNT_W-1:0] count;
    index_t           read_index;
    instruction_t     instruction;
    logic             res_valid;
    logic             res_ready;
    result_t          result;
    opcode_t          res_opcode;
    index_t           res_index;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    instruction_t mem [DEPTH];
    vec_t         vt  [16];
    beat_t        exp_q [$];

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int done_cyc    = 0;
    int last_acc    = -1;
    int first_valid = -1;
    int beats_acc   = 0;
    int win_acc     = 0;
    bit mon_en      = 1'b0;

    instr_exec_unit dut (
        .clk         (clk),
        .reset_en    (reset_en),
        .start       (start),
        .start_index (start_index),
        .count       (count),
        .read_index  (read_index),
        .instruction (instruction),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .res_opcode  (res_opcode),
        .res_index   (res_index),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb instruction = mem[read_index];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference execution from the arithmetic rules on 64-bit integers
    function automatic beat_t model(input instruction_t ins, input int idx);
        beat_t  e;
        longint a;
        longint b;
        a     = longint'(ins.op_a);
        b     = longint'(ins.op_b);
        e.op  = ins.opc;
        e.idx = idx;
        e.d0  = 1'b0;
        e.r   = 0;
        case (ins.opc)
            PASSA: e.r = a;
            PASSB: e.r = b;
            ADD:   e.r = a + b;
            SUB:   e.r = a - b;
            MULT:  e.r = a * b;
            DIV:   if (b == 0) e.d0 = 1'b1; else e.r = a / b;
            MOD:   if (b == 0) e.d0 = 1'b1; else e.r = a - (a / b) * b;
            default: e.r = 0;
        endcase
        return e;
    endfunction

    task automatic push_model(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = (s + i) % DEPTH;
            exp_q.push_back(model(mem[idx], idx));
        end
    endtask

    function automatic int rand_operand();
        case ($urandom_range(4))
            0:       return 0;
            1:       return int'($urandom_range(20)) - 10;
            2:       return int'(32'h8000_0000);
            3:       return -1;
            default: return int'($urandom);
        endcase
    endfunction

    // Scoreboard: every presented beat must match the head of the expected queue
    always @(negedge clk) begin
        if (mon_en && reset_en) begin
            if (res_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check("beat_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("result",      result,      exp_q[0].r);
                    check("res_opcode",  res_opcode,  exp_q[0].op);
                    check("res_index",   res_index,   exp_q[0].idx);
                    check("div_by_zero", div_by_zero, exp_q[0].d0);
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        last_acc = cyc;
                        beats_acc++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Issues one window and waits (bounded) for its done pulse
    task automatic run_window(input int s, input int n, input int ready_pct,
                              input bit stall_b2, input bit busy_start);
        int d0cnt;
        int base;
        int t;
        index_t exp_ri;
        index_t exp_rx;
        exp_ri      = index_t'(s + 4);
        exp_rx      = index_t'(s + 2);
        first_valid = -1;
        d0cnt       = done_cnt;
        base        = beats_acc;
        start       = 1'b1;
        start_index = index_t'(s);
        count       = CNT_W'(n);
        @(posedge clk); #1;
        start   = 1'b0;
        win_acc = cyc;
        t       = 0;
        while (done_cnt == d0cnt && t < 400) begin
            if (stall_b2) res_ready = !(cyc >= win_acc + 4 && cyc <= win_acc + 6);
            else          res_ready = ($urandom_range(99) < ready_pct);
            if (busy_start && t == 2) begin
                start       = 1'b1;
                start_index = index_t'(s + 5);
                count       = CNT_W'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (stall_b2 && !res_ready) begin
                check("stall_read_index", read_index, exp_ri);
                check("stall_res_index",  res_index,  exp_rx);
                check("stall_res_valid",  res_valid,  1);
            end
            if (n == 0) begin
                check("empty_busy",      busy,      0);
                check("empty_res_valid", res_valid, 0);
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        check("done_seen_once",   done_cnt - d0cnt,  1);
        check("queue_drained",    exp_q.size(),      0);
        check("beat_count",       beats_acc - base,  n);
        if (n == 0) check("done_empty_timing", done_cyc, win_acc);
        else        check("done_after_last",   done_cyc, last_acc + 1);
        @(negedge clk);
        check("busy_after_done",  busy, 0);
        check("done_one_cycle",   done, 0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic set_vec(input int k, input opcode_t o, input int a, input int b,
                           input longint r, input bit d0, input int idx);
        vt[k].opc = o;  vt[k].a  = a;  vt[k].b   = b;
        vt[k].r   = r;  vt[k].d0 = d0; vt[k].idx = idx;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t;
        int dc;
        reset_en    = 1'b0;
        start       = 1'b0;
        start_index = '0;
        count       = '0;
        res_ready   = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid",   res_valid,   0);
        check("rst_busy",        busy,        0);
        check("rst_done",        done,        0);
        check("rst_read_index",  read_index,  0);
        check("rst_result",      result,      0);
        check("rst_res_index",   res_index,   0);
        check("rst_div_by_zero", div_by_zero, 0);
        reset_en = 1'b1;
        mon_en   = 1'b1;
        @(posedge clk); #1;

        // Vector table: {opcode, a, b, expected result, expected div0, entry}
        set_vec( 0, ADD,   5,  3,  8,  0, 0);
        set_vec( 1, SUB,   5,  8, -3,  0, 1);
        set_vec( 2, MULT, -4,  6, -24, 0, 2);
        set_vec( 3, PASSB, 1,  9,  9,  0, 3);
        set_vec( 4, DIV,   7,  0,  0,  1, 7);
        set_vec( 5, MOD,  -7,  2, -1,  0, 8);
        set_vec( 6, DIV,  int'(32'h8000_0000), -1, 64'sd2147483648, 0, 9);
        set_vec( 7, MULT, int'(32'h8000_0000), int'(32'h8000_0000), 64'sd4611686018427387904, 0, 10);
        set_vec( 8, DIV,  -7,  2, -3,  0, 11);
        set_vec( 9, MOD,   7, -2,  1,  0, 12);
        set_vec(10, MOD,   5,  0,  0,  1, 13);
        set_vec(11, ZERO,  9,  9,  0,  0, 14);
        set_vec(12, PASSA, -9, 1, -9,  0, 15);
        set_vec(13, SUB,  int'(32'h8000_0000), 1, -64'sd2147483649, 0, 16);
        set_vec(14, ADD,  32'sd2147483647, 32'sd2147483647, 64'sd4294967294, 0, 17);
        set_vec(15, MULT, 32'sd2147483647, -1, -64'sd2147483647, 0, 18);
        for (int k = 0; k < 16; k++) begin
            mem[vt[k].idx].opc  = vt[k].opc;
            mem[vt[k].idx].op_a = vt[k].a;
            mem[vt[k].idx].op_b = vt[k].b;
        end

        // Basic window with full throughput and latency checks
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{r: vt[k].r, op: vt[k].opc, idx: vt[k].idx, d0: vt[k].d0});
        run_window(0, 4, 100, 1'b0, 1'b0);
        check("first_beat_latency", first_valid, win_acc + 2);
        check("back_to_back_beats", last_acc,    win_acc + 5);

        // Divide-by-zero and the remaining table entries
        for (int k = 4; k < 16; k++)
            exp_q.push_back('{r: vt[k].r, op: vt[k].opc, idx: vt[k].idx, d0: vt[k].d0});
        run_window(7, 12, 100, 1'b0, 1'b0);

        // Window wrapping past the last entry
        mem[DEPTH-2] = '{opc: ADD,  op_a: 32'sd1,  op_b: 32'sd2};
        mem[DEPTH-1] = '{opc: SUB,  op_a: 32'sd10, op_b: 32'sd4};
        mem[0]       = '{opc: MULT, op_a: -32'sd3, op_b: 32'sd3};
        mem[1]       = '{opc: DIV,  op_a: 32'sd9,  op_b: 32'sd2};
        push_model(DEPTH - 2, 4);
        run_window(DEPTH - 2, 4, 100, 1'b0, 1'b0);

        // Backpressure held for three cycles on the third beat
        push_model(10, 8);
        run_window(10, 8, 100, 1'b1, 1'b0);

        // Asynchronous reset mid-window after two accepted beats
        push_model(0, 8);
        base        = beats_acc;
        res_ready   = 1'b1;
        start       = 1'b1;
        start_index = '0;
        count       = CNT_W'(8);
        @(posedge clk); #1;
        start = 1'b0;
        t     = 0;
        while (beats_acc - base < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("reset_pre_beats", beats_acc - base, 2);
        dc = done_cnt;
        #2;
        reset_en = 1'b0;
        #1;
        check("areset_res_valid",  res_valid,  0);
        check("areset_busy",       busy,       0);
        check("areset_result",     result,     0);
        check("areset_read_index", read_index, 0);
        check("areset_done",       done,       0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        reset_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt - dc, 0);
        check("idle_after_abort",    busy,          0);

        // Fresh window with a start pulse while busy that must be ignored
        push_model(3, 6);
        run_window(3, 6, 100, 1'b0, 1'b1);

        // Empty window
        run_window(5, 0, 100, 1'b0, 1'b0);

        // Randomised windows against the reference model
        for (int w = 0; w < 25; w++) begin
            int s;
            int n;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].opc  = opcode_t'($urandom_range(7));
                mem[i].op_a = rand_operand();
                mem[i].op_b = rand_operand();
            end
            s = $urandom_range(DEPTH - 1);
            n = (w == 0) ? DEPTH : int'($urandom_range(DEPTH));
            push_model(s, n);
            run_window(s, n, int'($urandom_range(100, 30)), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
